mdr_gearbox: RTL

- Parametrised memory data register that converts between a narrow memory beat bus and a full CPU data word.
- LOAD mode assembles NBEATS incoming beats into the word with auto-sequenced lane selection.
- STORE mode serialises a word into beats with a valid/ready handshake.
- MANUAL mode keeps one-hot direct lane writes, so existing controller sequencing still works. Sits between the memory interface and the datapath.

---
 rtl/mdr_gearbox.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mdr_gearbox.sv
// rtl/mdr_gearbox.sv - memory data register gearbox between a narrow beat bus and a CPU word
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   en[NBEATS]              one-hot manual lane write (IDLE only), data from mem_rdata
//   start_load              assemble NBEATS beats from mem_rdata/mem_rvalid into register
//   start_store, st_word    serialise st_word onto mem_wdata/mem_wvalid/mem_wready
//   abort                   cancel the current LOAD/STORE, no done pulse
//   register                assembled / held word
//   busy, done, beat_idx    transfer status, one-cycle completion pulse, beat counter
module mdr_gearbox #(
    parameter int WORD_W    = 16,
    parameter int BEAT_W    = 4,
    parameter int MSB_FIRST = 1,
    localparam int NBEATS   = WORD_W / BEAT_W,
    localparam int CW       = $clog2(NBEATS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NBEATS-1:0] en,
    input  logic              start_load,
    input  logic              start_store,
    input  logic [WORD_W-1:0] st_word,
    input  logic              abort,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [BEAT_W-1:0] mem_wdata,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [WORD_W-1:0] register,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     beat_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t state;

    // Lane occupied by beat k.
    function automatic int lane_pos(input logic [CW-1:0] k);
        return (MSB_FIRST != 0) ? (NBEATS - 1 - int'(k)) : int'(k);
    endfunction

    logic last_beat;
    logic en_onehot;

    assign last_beat  = (beat_idx == CW'(NBEATS - 1));
    // Multi-lane or empty enables are ignored so no partial multi-lane writes happen.
    assign en_onehot  = (en != '0) && ((en & (en - NBEATS'(1))) == '0);

    assign busy       = (state != IDLE);
    assign mem_wvalid = (state == STORE);
    assign mem_wdata  = register[lane_pos(beat_idx)*BEAT_W +: BEAT_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            register <= '0;
            beat_idx <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_load) begin
                        state    <= LOAD;
                        beat_idx <= '0;
                    end else if (start_store) begin
                        register <= st_word;
                        state    <= STORE;
                        beat_idx <= '0;
                    end else if (en_onehot) begin
                        for (int i = 0; i < NBEATS; i++) begin
                            if (en[i]) register[i*BEAT_W +: BEAT_W] <= mem_rdata;
                        end
                    end
                end
                LOAD: begin
                    // The beat is captured even when abort arrives with it.
                    if (mem_rvalid) begin
                        for (int i = 0; i < NBEATS; i++) begin
                            if (i == lane_pos(beat_idx)) register[i*BEAT_W +: BEAT_W] <= mem_rdata;
                        end
                    end
                    if (abort) begin
                        state    <= IDLE;
                        beat_idx <= '0;
                    end else if (mem_rvalid) begin
                        if (last_beat) begin
                            state    <= IDLE;
                            beat_idx <= '0;
                            done     <= 1'b1;
                        end else begin
                            beat_idx <= beat_idx + CW'(1);
                        end
                    end
                end
                STORE: begin
                    if (abort) begin
                        state    <= IDLE;
                        beat_idx <= '0;
                    end else if (mem_wready) begin
                        if (last_beat) begin
                            state    <= IDLE;
                            beat_idx <= '0;
                            done     <= 1'b1;
                        end else begin
                            beat_idx <= beat_idx + CW'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_idx <= '0;
                end
            endcase
        end
    end

endmodule
